// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the MSB-first serial compare path
// (serializer and comparator).
package serial_cmp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Counter width for a W-bit word. The counter must be able to hold W-1,
  // and it keeps at least one bit so that W=1 still has a real register.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_pair_serializer_msb_first.sv
// Serializes a pair of W-bit words (a, b) into one bit pair per beat, MSB first,
// and marks each frame with out_first / out_last. Back-to-back words stream
// with no bubble because the next pair is accepted on the last beat.
// Optional feature: SERIAL_SERIALIZER_EARLY_EXIT_EN ends the frame at the first
// beat where the two bits differ.
module serial_pair_serializer_msb_first
  import serial_cmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_a,
  output logic         out_b,
  output logic         out_first,
  output logic         out_last
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

  ser_state_t     state, state_nxt;
  logic [W-1:0]   sh_a, sh_a_nxt;
  logic [W-1:0]   sh_b, sh_b_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           first, first_nxt;
  logic           last_bit;
  logic           beat;

  // Next-state, datapath update and output decode.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nxt = state;
    sh_a_nxt  = sh_a;
    sh_b_nxt  = sh_b;
    cnt_nxt   = cnt;
    first_nxt = first;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_a     = 1'b0;
    out_b     = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    last_bit  = 1'b0;
    beat      = 1'b0;

    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_a_nxt  = in_a;
          sh_b_nxt  = in_b;
          cnt_nxt   = CNT_LOAD;
          first_nxt = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
`ifdef SERIAL_SERIALIZER_EARLY_EXIT_EN
        // Once the bits differ the comparator's verdict is fixed; drop the rest.
        last_bit = (cnt == '0) || (sh_a[W-1] != sh_b[W-1]);
`else
        last_bit = (cnt == '0);
`endif
        out_valid = 1'b1;
        out_a     = sh_a[W-1];
        out_b     = sh_b[W-1];
        out_first = first;
        out_last  = last_bit;
        beat      = out_ready;
        // Ready on the last beat lets the next pair load with no idle cycle.
        in_ready  = beat & last_bit;

        if (beat) begin
          if (last_bit) begin
            if (in_valid) begin
              sh_a_nxt  = in_a;
              sh_b_nxt  = in_b;
              cnt_nxt   = CNT_LOAD;
              first_nxt = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            sh_a_nxt  = sh_a << 1;
            sh_b_nxt  = sh_b << 1;
            cnt_nxt   = cnt - 1'b1;
            first_nxt = 1'b0;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      first <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state <= state_nxt;
      sh_a  <= sh_a_nxt;
      sh_b  <= sh_b_nxt;
      cnt   <= cnt_nxt;
      first <= first_nxt;
    end
  end

endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// Testbench for serial_pair_serializer_msb_first: three instances (W=4, W=8,
// W=1) exercised one at a time. Stimulus pushes expected beats and compare
// verdicts into queues; a separate monitor pops and compares on each beat.
module tb_serial_pair_serializer_msb_first;

`ifdef SERIAL_SERIALIZER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int WID [3] = '{4, 8, 1};

  typedef struct packed {
    logic a;
    logic b;
    logic first;
    logic last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [2:0]      in_valid  = '0;
  logic [2:0]      out_ready = '1;
  logic [2:0][7:0] in_a      = '0;
  logic [2:0][7:0] in_b      = '0;
  logic [2:0]      in_ready, out_valid, out_a, out_b, out_first, out_last;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t exp_q[$];
  int    verdict_q[$];   // 0: a<b, 1: a==b, 2: a>b

  always #5 clk = ~clk;

  serial_pair_serializer_msb_first #(.W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0][3:0]), .in_b(in_b[0][3:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_a(out_a[0]), .out_b(out_b[0]),
    .out_first(out_first[0]), .out_last(out_last[0])
  );

  serial_pair_serializer_msb_first #(.W(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_a(out_a[1]), .out_b(out_b[1]),
    .out_first(out_first[1]), .out_last(out_last[1])
  );

  serial_pair_serializer_msb_first #(.W(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2][0:0]), .in_b(in_b[2][0:0]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_a(out_a[2]), .out_b(out_b[2]),
    .out_first(out_first[2]), .out_last(out_last[2])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Number of beats a frame takes: all n bits, or up to the first differing
  // bit when early exit is built in.
  function automatic int frame_len(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = n - 1; i >= 0; i--)
      if (EARLY && (a[i] != b[i])) return n - i;
    return n;
  endfunction

  // Reference: the beats a frame should produce, plus the compare verdict.
  task automatic push_frame(input int k, input logic [7:0] a, input logic [7:0] b);
    int n;
    int len;
    int va;
    int vb;
    beat_t bt;
    n   = WID[k];
    len = frame_len(a, b, n);
    for (int j = 0; j < len; j++) begin
      bt.a     = a[n-1-j];
      bt.b     = b[n-1-j];
      bt.first = (j == 0);
      bt.last  = (j == len - 1);
      exp_q.push_back(bt);
    end
    va = int'(a) % (1 << n);
    vb = int'(b) % (1 << n);
    verdict_q.push_back(va < vb ? 0 : (va == vb ? 1 : 2));
  endtask

  // One cycle of stimulus on instance k; reports whether the pair was accepted.
  task automatic step(input int k, input bit v, input logic [7:0] a, input logic [7:0] b,
                      input bit r, output bit acc);
    @(negedge clk);
    in_valid[k]  = v;
    in_a[k]      = a;
    in_b[k]      = b;
    out_ready[k] = r;
    #1;
    acc = v && in_ready[k];
    if (acc) push_frame(k, a, b);
  endtask

  // Monitor: compares each beat against the queue, rebuilds the serial compare
  // verdict per frame, and checks output stability under backpressure.
  initial begin : monitor
    bit    held [3];
    beat_t saved [3];
    int    cur [3];
    beat_t got;
    beat_t exp;
    int    vexp;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        for (int k = 0; k < 3; k++) begin
          held[k] = 1'b0;
          cur[k]  = 1;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          got = '{a: out_a[k], b: out_b[k], first: out_first[k], last: out_last[k]};
          if (held[k]) begin
            check("hold_valid", 32'(out_valid[k]), 32'd1);
            check("hold_bits", 32'(got), 32'(saved[k]));
          end
          if (!out_valid[k]) begin
            check("idle_zero", 32'(got), 32'd0);
            held[k] = 1'b0;
          end else if (out_ready[k]) begin
            held[k] = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
            end else begin
              exp = exp_q.pop_front();
              check("beat", 32'(got), 32'(exp));
            end
            if (got.first) cur[k] = 1;
            if (cur[k] == 1 && got.a != got.b) cur[k] = got.a ? 2 : 0;
            if (got.last) begin
              if (verdict_q.size() == 0) begin
                check("unexpected_verdict", 32'(cur[k]), 32'hFFFF_FFFF);
              end else begin
                vexp = verdict_q.pop_front();
                check("verdict", 32'(cur[k]), 32'(vexp));
              end
            end
          end else begin
            held[k]  = 1'b1;
            saved[k] = got;
          end
        end
      end
    end
  end

  task automatic drain(input int k, input string name);
    bit acc;
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      step(k, 1'b0, 8'h00, 8'h00, 1'b1, acc);
      guard++;
    end
    step(k, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    bit acc;
    int len1;
    int len2;
    int accepted;
    int cycles;
    logic [7:0] ra;
    logic [7:0] rb;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", 32'(out_valid[k]), 32'd0);
      check("rst_in_ready", 32'(in_ready[k]), 32'd1);
      check("rst_outs", 32'({out_a[k], out_b[k], out_first[k], out_last[k]}), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Single word on W=4.
    step(0, 1'b1, 8'h0A, 8'h09, 1'b1, acc);
    check("single_accept", 32'(acc), 32'd1);
    drain(0, "single_drained");

    // Reset mid-frame, then a clean word.
    step(0, 1'b1, 8'h0C, 8'h0C, 1'b1, acc);
    step(0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    step(0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    check("midrst_outs", 32'({out_a[0], out_b[0], out_first[0], out_last[0]}), 32'd0);
    exp_q.delete();
    verdict_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(0, 1'b1, 8'h06, 8'h05, 1'b1, acc);
    drain(0, "post_rst_drained");

    // Backpressure on beat 2.
    step(0, 1'b1, 8'h0B, 8'h0B, 1'b1, acc);
    step(0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    repeat (3) step(0, 1'b0, 8'h00, 8'h00, 1'b0, acc);
    drain(0, "bp_drained");

    // Back-to-back: F/0 then 0/F with in_valid held.
    len1 = frame_len(8'h0F, 8'h00, 4);
    len2 = frame_len(8'h00, 8'h0F, 4);
    step(0, 1'b1, 8'h0F, 8'h00, 1'b1, acc);
    for (int c = 1; c <= len1 + len2; c++) begin
      step(0, c <= len1, 8'h00, 8'h0F, 1'b1, acc);
      check("b2b_valid", 32'(out_valid[0]), 32'd1);
      if (c <= len1) check("b2b_in_ready", 32'(in_ready[0]), 32'(c == len1));
    end
    step(0, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    check("b2b_idle", 32'(out_valid[0]), 32'd0);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // W=1 single beat.
    step(2, 1'b1, 8'h01, 8'h00, 1'b1, acc);
    step(2, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    check("w1_beat", 32'({out_valid[2], out_first[2], out_last[2]}), 32'h7);
    step(2, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    check("w1_idle", 32'({out_valid[2], in_ready[2]}), 32'h1);

    // Random traffic on W=8.
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 40000) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : ($urandom_range(0, 1) == 0 ? ra ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom));
      step(1, $urandom_range(0, 9) < 7, ra, rb, $urandom_range(0, 3) != 0, acc);
      if (acc) accepted++;
      cycles++;
    end
    check("rand_accepted", 32'(accepted), 32'd1000);
    drain(1, "rand_drained");
    check("rand_verdicts", 32'(verdict_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
